// File: rtl/spi_frame_packer.sv
// Buffers 48-bit FFT samples and streams each as an 8-byte frame (sync, 6 data, XOR checksum)
// to an SPI master byte interface, with an inter-frame gap and a fixed frame count per burst.
module spi_frame_packer #(
  parameter int         FIFO_DEPTH       = 16,
  parameter int         GAP_CYCLES       = 500000,
  parameter int         FRAMES_PER_BURST = 1024,
  parameter logic [7:0] SYNC_BYTE        = 8'hA5
) (
  input  logic                                  CLK100MHZ,
  input  logic                                  RESET,
  input  logic [47:0]                           s_sample_data,
  input  logic                                  s_sample_valid,
  output logic                                  s_sample_ready,
  input  logic                                  i_burst_start,
  output logic [7:0]                            o_tx_byte,
  output logic                                  o_tx_dv,
  input  logic                                  i_tx_ready,
  output logic                                  o_busy,
  output logic                                  o_burst_done,
  output logic [$clog2(FRAMES_PER_BURST+1)-1:0] o_frame_count,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]       o_fifo_level
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int LW  = $clog2(FIFO_DEPTH + 1);
  localparam int FCW = $clog2(FRAMES_PER_BURST + 1);
  localparam int GW  = $clog2(GAP_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LOAD,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t          state_q;
  logic [47:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic            push, pop;

  logic [47:0]     sample_q;
  logic [7:0]      chk_q;
  logic [2:0]      byte_idx_q;
  logic [7:0]      cur_byte_d;
  logic [GW-1:0]   gap_cnt_q;
  logic [FCW-1:0]  frame_cnt_q;
  logic [7:0]      tx_byte_q;
  logic            tx_dv_q;
  logic            burst_done_q;

  // Writes are gated on registered occupancy only, so a pop at full never frees a slot early.
  assign s_sample_ready = (level_q != LW'(FIFO_DEPTH));
  assign push           = s_sample_valid && s_sample_ready;
  assign pop            = (state_q == S_WAIT) && (level_q != '0);

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (push) mem_q[wr_ptr_q] <= s_sample_data;
  end

  always_ff @(posedge CLK100MHZ or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q <= level_d;
    end
  end

  always_comb begin
    cur_byte_d = SYNC_BYTE;
    case (byte_idx_q)
      3'd0: cur_byte_d = SYNC_BYTE;
      3'd1: cur_byte_d = sample_q[47:40];
      3'd2: cur_byte_d = sample_q[39:32];
      3'd3: cur_byte_d = sample_q[31:24];
      3'd4: cur_byte_d = sample_q[23:16];
      3'd5: cur_byte_d = sample_q[15:8];
      3'd6: cur_byte_d = sample_q[7:0];
      default: cur_byte_d = chk_q;
    endcase
  end

  // Strobe only when dv was low last cycle: the master needs a cycle to drop its ready.
  always_ff @(posedge CLK100MHZ or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      sample_q     <= '0;
      chk_q        <= '0;
      byte_idx_q   <= '0;
      gap_cnt_q    <= '0;
      frame_cnt_q  <= '0;
      tx_byte_q    <= '0;
      tx_dv_q      <= 1'b0;
      burst_done_q <= 1'b0;
    end else begin
      tx_dv_q      <= 1'b0;
      burst_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_burst_start) begin
            frame_cnt_q <= '0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (pop) begin
            sample_q <= mem_q[rd_ptr_q];
            state_q  <= S_LOAD;
          end
        end
        S_LOAD: begin
          chk_q      <= SYNC_BYTE ^ sample_q[47:40] ^ sample_q[39:32] ^ sample_q[31:24]
                        ^ sample_q[23:16] ^ sample_q[15:8] ^ sample_q[7:0];
          byte_idx_q <= '0;
          state_q    <= S_SEND;
        end
        S_SEND: begin
          if (i_tx_ready && !tx_dv_q) begin
            tx_dv_q    <= 1'b1;
            tx_byte_q  <= cur_byte_d;
            byte_idx_q <= byte_idx_q + 3'd1;
            if (byte_idx_q == 3'd7) begin
              gap_cnt_q <= '0;
              state_q   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          gap_cnt_q <= gap_cnt_q + GW'(1);
          if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
            frame_cnt_q <= frame_cnt_q + FCW'(1);
            if (frame_cnt_q + FCW'(1) == FCW'(FRAMES_PER_BURST)) begin
              burst_done_q <= 1'b1;
              state_q      <= S_DONE;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_tx_byte     = tx_byte_q;
  assign o_tx_dv       = tx_dv_q;
  assign o_busy        = (state_q != S_IDLE);
  assign o_burst_done  = burst_done_q;
  assign o_frame_count = frame_cnt_q;
  assign o_fifo_level  = level_q;

endmodule

// File: tb/tb_spi_frame_packer.sv
// Directed bench for spi_frame_packer: a simple SPI master model answers the byte handshake
// while a linear sequence of steps checks framing, FIFO behaviour, bursts and reset.
module tb_spi_frame_packer;

  localparam int         FIFO_DEPTH       = 4;
  localparam int         GAP_CYCLES       = 64;
  localparam int         FRAMES_PER_BURST = 3;
  localparam logic [7:0] SYNC             = 8'hA5;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] sData;
  logic        sValid;
  logic        sReady;
  logic        burstStart;
  logic [7:0]  txByte;
  logic        txDv;
  logic        txReady = 1'b1;
  logic        busy;
  logic        burstDone;
  logic [1:0]  frameCount;
  logic [2:0]  fifoLevel;

  always #5 clk = ~clk;

  spi_frame_packer #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .GAP_CYCLES(GAP_CYCLES),
    .FRAMES_PER_BURST(FRAMES_PER_BURST),
    .SYNC_BYTE(SYNC)
  ) dut (
    .CLK100MHZ(clk),
    .RESET(rst),
    .s_sample_data(sData),
    .s_sample_valid(sValid),
    .s_sample_ready(sReady),
    .i_burst_start(burstStart),
    .o_tx_byte(txByte),
    .o_tx_dv(txDv),
    .i_tx_ready(txReady),
    .o_busy(busy),
    .o_burst_done(burstDone),
    .o_frame_count(frameCount),
    .o_fifo_level(fifoLevel)
  );

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic       fastMode = 1'b0;
  int         busyCnt = 0;
  logic       prevDv = 1'b0;
  logic       prevDone = 1'b0;
  logic       byteValid = 1'b0;
  logic [7:0] lastByte = 8'h00;
  int         dvViol = 0;
  int         stableViol = 0;
  int         doneWidthViol = 0;
  int         doneCount = 0;
  int         lastDvCycle = 0;
  int         doneCycle = 0;
  logic [7:0] capQ[$];
  logic [7:0] expQ[$];
  logic [7:0] hand[8];

  always @(posedge clk) cyc <= cyc + 1;

  // Master model: ready drops right after each strobe and recovers 40 cycles later (or stays high in fast mode).
  always @(negedge clk) begin
    if (rst) begin
      busyCnt   = 0;
      txReady   = 1'b1;
      prevDv    = 1'b0;
      prevDone  = 1'b0;
      byteValid = 1'b0;
    end else begin
      if (txDv) begin
        capQ.push_back(txByte);
        lastByte    = txByte;
        byteValid   = 1'b1;
        lastDvCycle = cyc;
        if (prevDv) dvViol++;
      end else if (byteValid && txByte !== lastByte) begin
        stableViol++;
      end
      if (burstDone) begin
        doneCount++;
        doneCycle = cyc;
        if (prevDone) doneWidthViol++;
      end
      if (fastMode) txReady = 1'b1;
      else if (txDv) begin
        txReady = 1'b0;
        busyCnt = 40;
      end else if (busyCnt > 0) begin
        busyCnt--;
        if (busyCnt == 0) txReady = 1'b1;
      end
      prevDv   = txDv;
      prevDone = burstDone;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [47:0] d);
    int n = 0;
    @(negedge clk);
    sData  = d;
    sValid = 1'b1;
    while (!sReady && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("pushTimeout", 64'(n >= 3000), 64'd0);
    @(negedge clk);
    sValid = 1'b0;
  endtask

  task automatic pulseStart();
    @(negedge clk);
    burstStart = 1'b1;
    @(negedge clk);
    burstStart = 1'b0;
  endtask

  task automatic waitDone(input int bound);
    int n = 0;
    int startDone = doneCount;
    while (doneCount == startDone && n < bound) begin
      @(negedge clk);
      n++;
    end
    checkOutput("doneTimeout", 64'(n >= bound), 64'd0);
  endtask

  task automatic waitBytes(input int cnt, input int bound);
    int n = 0;
    while (capQ.size() < cnt && n < bound) begin
      @(negedge clk);
      n++;
    end
    checkOutput("byteTimeout", 64'(n >= bound), 64'd0);
  endtask

  task automatic expectFrame(input logic [47:0] s);
    logic [7:0] chk = SYNC;
    expQ.push_back(SYNC);
    for (int i = 5; i >= 0; i--) begin
      expQ.push_back(s[i*8 +: 8]);
      chk = chk ^ s[i*8 +: 8];
    end
    expQ.push_back(chk);
  endtask

  task automatic checkFrames(input string tag);
    int n;
    checkOutput($sformatf("%s.byteCount", tag), 64'(capQ.size()), 64'(expQ.size()));
    n = (capQ.size() < expQ.size()) ? capQ.size() : expQ.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s.byte%0d", tag, i), 64'(capQ[i]), 64'(expQ[i]));
    capQ.delete();
    expQ.delete();
  endtask

  task automatic clearMonitors();
    capQ.delete();
    expQ.delete();
    doneCount     = 0;
    dvViol        = 0;
    stableViol    = 0;
    doneWidthViol = 0;
  endtask

  initial begin
    int d;
    int n;
    rst        = 1'b1;
    sData      = '0;
    sValid     = 1'b0;
    burstStart = 1'b0;
    hand = '{8'hA5, 8'hF1, 8'h02, 8'h03, 8'h04, 8'h05, 8'h6F, 8'h3B};
    repeat (3) @(negedge clk);
    checkOutput("rst.dv", 64'(txDv), 64'd0);
    checkOutput("rst.byte", 64'(txByte), 64'h00);
    checkOutput("rst.done", 64'(burstDone), 64'd0);
    checkOutput("rst.busy", 64'(busy), 64'd0);
    checkOutput("rst.count", 64'(frameCount), 64'd0);
    checkOutput("rst.level", 64'(fifoLevel), 64'd0);
    checkOutput("rst.ready", 64'(sReady), 64'd1);
    rst = 1'b0;

    $display("[TB] step 1: slow master, framing and gap");
    clearMonitors();
    applyStimulus(48'hF1020304056F);
    applyStimulus(48'h112233445566);
    applyStimulus(48'hFFEE00DDCC01);
    checkOutput("t1.level", 64'(fifoLevel), 64'd3);
    pulseStart();
    checkOutput("t1.busy", 64'(busy), 64'd1);
    waitDone(5000);
    d = doneCycle - lastDvCycle;
    checkOutput($sformatf("t1.doneDelay=%0d", d), 64'(d >= GAP_CYCLES && d <= GAP_CYCLES + 4), 64'd1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("t1.hand%0d", i), 64'(capQ[i]), 64'(hand[i]));
    expectFrame(48'hF1020304056F);
    expectFrame(48'h112233445566);
    expectFrame(48'hFFEE00DDCC01);
    checkFrames("t1");
    checkOutput("t1.count", 64'(frameCount), 64'd3);
    checkOutput("t1.busyAfter", 64'(busy), 64'd0);
    checkOutput("t1.doneCount", 64'(doneCount), 64'd1);
    checkOutput("t1.doneWidth", 64'(doneWidthViol), 64'd0);
    checkOutput("t1.dvViol", 64'(dvViol), 64'd0);

    $display("[TB] step 2: ready held high");
    clearMonitors();
    fastMode = 1'b1;
    applyStimulus(48'h0123456789AB);
    applyStimulus(48'h800000000001);
    applyStimulus(48'h5A5A5A5A5A5A);
    pulseStart();
    waitDone(2000);
    repeat (2) @(negedge clk);
    checkOutput("t2.dvViol", 64'(dvViol), 64'd0);
    checkOutput("t2.stable", 64'(stableViol), 64'd0);
    expectFrame(48'h0123456789AB);
    expectFrame(48'h800000000001);
    expectFrame(48'h5A5A5A5A5A5A);
    checkFrames("t2");

    $display("[TB] step 3: FIFO full and ordering");
    clearMonitors();
    applyStimulus(48'h000000000010);
    applyStimulus(48'h000000000011);
    applyStimulus(48'h000000000012);
    applyStimulus(48'h000000000013);
    checkOutput("t3.levelFull", 64'(fifoLevel), 64'd4);
    checkOutput("t3.readyFull", 64'(sReady), 64'd0);
    @(negedge clk);
    sData  = 48'h000000000014;
    sValid = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("t3.levelStall", 64'(fifoLevel), 64'd4);
    checkOutput("t3.readyStall", 64'(sReady), 64'd0);
    pulseStart();
    n = 0;
    while (!sReady && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t3.popTimeout", 64'(n >= 100), 64'd0);
    @(negedge clk);
    sValid = 1'b0;
    applyStimulus(48'h000000000015);
    waitDone(2000);
    repeat (2) @(negedge clk);
    checkOutput("t3.levelMid", 64'(fifoLevel), 64'd3);
    for (int i = 0; i < 3; i++) expectFrame(48'h10 + 48'(i));
    checkFrames("t3a");
    pulseStart();
    waitDone(2000);
    repeat (2) @(negedge clk);
    for (int i = 3; i < 6; i++) expectFrame(48'h10 + 48'(i));
    checkFrames("t3b");
    checkOutput("t3.levelEnd", 64'(fifoLevel), 64'd0);

    $display("[TB] step 4: starvation");
    clearMonitors();
    applyStimulus(48'hC0FFEE000001);
    pulseStart();
    waitBytes(8, 500);
    repeat (100) @(negedge clk);
    checkOutput("t4.busyWait", 64'(busy), 64'd1);
    checkOutput("t4.countWait", 64'(frameCount), 64'd1);
    checkOutput("t4.doneWait", 64'(doneCount), 64'd0);
    applyStimulus(48'hC0FFEE000002);
    applyStimulus(48'hC0FFEE000003);
    waitDone(2000);
    repeat (3) @(negedge clk);
    checkOutput("t4.count", 64'(frameCount), 64'd3);
    checkOutput("t4.doneCount", 64'(doneCount), 64'd1);
    checkOutput("t4.busyEnd", 64'(busy), 64'd0);
    expectFrame(48'hC0FFEE000001);
    expectFrame(48'hC0FFEE000002);
    expectFrame(48'hC0FFEE000003);
    checkFrames("t4");

    $display("[TB] step 5: reset mid-frame");
    clearMonitors();
    fastMode = 1'b0;
    applyStimulus(48'hDEADBEEF0001);
    applyStimulus(48'hDEADBEEF0002);
    pulseStart();
    waitBytes(4, 1000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("t5.dv", 64'(txDv), 64'd0);
    checkOutput("t5.byte", 64'(txByte), 64'h00);
    checkOutput("t5.busy", 64'(busy), 64'd0);
    checkOutput("t5.count", 64'(frameCount), 64'd0);
    checkOutput("t5.level", 64'(fifoLevel), 64'd0);
    checkOutput("t5.done", 64'(burstDone), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    clearMonitors();
    applyStimulus(48'h0A0B0C0D0E0F);
    applyStimulus(48'h102030405060);
    applyStimulus(48'h7F7F7F7F7F7F);
    pulseStart();
    waitDone(5000);
    repeat (2) @(negedge clk);
    expectFrame(48'h0A0B0C0D0E0F);
    expectFrame(48'h102030405060);
    expectFrame(48'h7F7F7F7F7F7F);
    checkFrames("t5");

    $display("[TB] step 6: start pulses while busy");
    clearMonitors();
    applyStimulus(48'h123456789ABC);
    applyStimulus(48'h0F0F0F0F0F0F);
    applyStimulus(48'hAAAA5555AAAA);
    pulseStart();
    waitBytes(3, 1000);
    pulseStart();
    waitBytes(8, 1000);
    repeat (10) @(negedge clk);
    pulseStart();
    checkOutput("t6.countGap", 64'(frameCount), 64'd0);
    waitDone(5000);
    repeat (3) @(negedge clk);
    checkOutput("t6.count", 64'(frameCount), 64'd3);
    checkOutput("t6.doneCount", 64'(doneCount), 64'd1);
    checkOutput("t6.busyEnd", 64'(busy), 64'd0);
    expectFrame(48'h123456789ABC);
    expectFrame(48'h0F0F0F0F0F0F);
    expectFrame(48'hAAAA5555AAAA);
    checkFrames("t6");
    checkOutput("t6.dvViol", 64'(dvViol), 64'd0);
    checkOutput("t6.stable", 64'(stableViol), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
